// File: rtl/timer_param_apb.sv
// WIDTH-bit APB timer: up/down count, load, pause, 2^n prescaler, ovf/udf flags, auto-reload, interrupt.
// Zero-wait-state APB slave (pready=1); optional compare register at 0x14 when TIMER_CMP_EN is defined.
module timer_param_apb #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              interrupt
);

   localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_TIER = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(8'h10);
`ifdef TIMER_CMP_EN
   localparam logic [ADDR_W-1:0] A_TCMP = ADDR_W'(8'h14);
   localparam logic [2:0]        FLAG_MASK = 3'b111;
`else
   localparam logic [2:0]        FLAG_MASK = 3'b011;
`endif

   logic [WIDTH-1:0] tdr, tcnt, cnt_nxt;
   logic             en, dir, div_en, auto_rld;
   logic [2:0]       div_val, tsr, tier, flag_set, w1c;
   logic [6:0]       presc, presc_mask;
   logic [7:0]       presc_one_hot;
   logic             wr, wr_tcr, load, div_chg, presc_hit, tick, at_max, at_zero;
   logic [31:0]      rd_mux;
   logic             unused_bits;

`ifdef TIMER_CMP_EN
   logic [WIDTH-1:0] tcmp;
`endif

   assign pready      = 1'b1;
   assign pslverr     = 1'b0;
   assign unused_bits = &{1'b0, pwdata};

   assign wr      = psel && penable && pwrite;
   assign wr_tcr  = wr && (paddr == A_TCR);
   assign load    = wr_tcr && pwdata[2];
   assign div_chg = wr_tcr && ((pwdata[3] != div_en) || (pwdata[6:4] != div_val));
   assign w1c     = (wr && (paddr == A_TSR)) ? (pwdata[2:0] & FLAG_MASK) : 3'b000;

   // Divide-by-2^div_val: the prescaler wraps when it reaches 2^div_val-1
   assign presc_one_hot = 8'd1 << div_val;
   assign presc_mask    = 7'(presc_one_hot - 8'd1);
   assign presc_hit     = (presc == presc_mask);
   assign tick          = en && (!div_en || presc_hit);

   assign at_max  = (tcnt == {WIDTH{1'b1}});
   assign at_zero = (tcnt == '0);

   always_comb begin
      cnt_nxt  = tcnt;
      flag_set = 3'b000;
      if (!dir) begin
         cnt_nxt     = at_max ? (auto_rld ? tdr : '0) : tcnt + 1'b1;
         flag_set[0] = at_max;
      end else begin
         cnt_nxt     = at_zero ? (auto_rld ? tdr : {WIDTH{1'b1}}) : tcnt - 1'b1;
         flag_set[1] = at_zero;
      end
`ifdef TIMER_CMP_EN
      flag_set[2] = (cnt_nxt == tcmp);
`endif
      // A load in the same cycle suppresses the tick and every flag it would raise
      if (!tick || load)
         flag_set = 3'b000;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tdr      <= '0;
         tcnt     <= '0;
         en       <= 1'b0;
         dir      <= 1'b0;
         div_en   <= 1'b0;
         div_val  <= 3'd0;
         auto_rld <= 1'b0;
         tsr      <= 3'b000;
         tier     <= 3'b000;
         presc    <= 7'd0;
`ifdef TIMER_CMP_EN
         tcmp     <= '0;
`endif
      end else begin
         if (wr && (paddr == A_TDR))
            tdr <= pwdata[WIDTH-1:0];
         if (wr && (paddr == A_TIER))
            tier <= pwdata[2:0] & FLAG_MASK;
`ifdef TIMER_CMP_EN
         if (wr && (paddr == A_TCMP))
            tcmp <= pwdata[WIDTH-1:0];
`endif
         if (wr_tcr) begin
            en       <= pwdata[0];
            dir      <= pwdata[1];
            div_en   <= pwdata[3];
            div_val  <= pwdata[6:4];
            auto_rld <= pwdata[7];
         end

         if (load)
            tcnt <= tdr;
         else if (tick)
            tcnt <= cnt_nxt;

         if (!en || !div_en || load || div_chg)
            presc <= 7'd0;
         else
            presc <= presc_hit ? 7'd0 : presc + 7'd1;

         // Hardware set beats a simultaneous software clear
         tsr <= (tsr & ~w1c) | flag_set;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (paddr)
         A_TDR:  rd_mux = 32'(tdr);
         A_TCR:  rd_mux = {24'd0, auto_rld, div_val, div_en, 1'b0, dir, en};
         A_TSR:  rd_mux = {29'd0, tsr};
         A_TIER: rd_mux = {29'd0, tier};
         A_TCNT: rd_mux = 32'(tcnt);
`ifdef TIMER_CMP_EN
         A_TCMP: rd_mux = 32'(tcmp);
`endif
         default: rd_mux = '0;
      endcase
   end

   assign prdata    = (psel && penable && !pwrite) ? rd_mux : 32'd0;
   assign interrupt = |(tsr & tier);

endmodule

// File: tb/tb_timer_param_apb.sv
// Bench for timer_param_apb (WIDTH=16): directed APB stimulus, read expectations queued and checked by a monitor.
module tb_timer_param_apb;

   localparam logic [7:0] A_TDR  = 8'h00;
   localparam logic [7:0] A_TCR  = 8'h04;
   localparam logic [7:0] A_TSR  = 8'h08;
   localparam logic [7:0] A_TIER = 8'h0C;
   localparam logic [7:0] A_TCNT = 8'h10;
   localparam logic [7:0] A_TCMP = 8'h14;
   localparam logic [7:0] A_BAD  = 8'h18;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  paddr = 8'h00;
   logic [31:0] pwdata = 32'd0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        interrupt;

   typedef struct {
      string       name;
      logic [31:0] exp;
      bit          chk_irq;
      bit          irq;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   timer_param_apb #(.WIDTH(16), .ADDR_W(8)) dut (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .interrupt(interrupt)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, pending=%0d", sbq.size());
      $fatal(1, "watchdog");
   end

   // Monitor: every read access phase pops one expectation
   always @(negedge pclk) begin
      if (presetn && psel && penable && !pwrite) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read addr=%h got=%h required=no read", paddr, prdata);
         end else begin
            mon_e = sbq.pop_front();
            if (prdata !== mon_e.exp) begin
               errors++;
               $display("FAIL %s prdata got=%h required=%h", mon_e.name, prdata, mon_e.exp);
            end
            if (mon_e.chk_irq) begin
               checks++;
               if (interrupt !== mon_e.irq) begin
                  errors++;
                  $display("FAIL %s interrupt got=%b required=%b", mon_e.name, interrupt, mon_e.irq);
               end
            end
            if (pready !== 1'b1 || pslverr !== 1'b0) begin
               errors++;
               $display("FAIL %s pready/pslverr got=%b%b required=10", mon_e.name, pready, pslverr);
            end
         end
      end
   end

   task automatic expect_rd(input string name, input logic [31:0] v);
      exp_t e;
      e.name = name; e.exp = v; e.chk_irq = 1'b0; e.irq = 1'b0;
      sbq.push_back(e);
   endtask

   task automatic expect_rd_irq(input string name, input logic [31:0] v, input bit irq);
      exp_t e;
      e.name = name; e.exp = v; e.chk_irq = 1'b1; e.irq = irq;
      sbq.push_back(e);
   endtask

   // All bus tasks start and end 1 time unit after a rising edge
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Hold the access phase on one address so the monitor samples it every cycle
   task automatic read_stream(input logic [7:0] a, input int n);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
      repeat (n) begin
         @(posedge pclk); #1;
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk); #1;
      end
   endtask

   initial begin
      idle(3);
      presetn = 1'b1;
      idle(1);

      // Reset values
      expect_rd("rst_tdr", 32'h0);     apb_read(A_TDR);
      expect_rd("rst_tcr", 32'h0);     apb_read(A_TCR);
      expect_rd_irq("rst_tsr", 32'h0, 1'b0); apb_read(A_TSR);
      expect_rd("rst_tier", 32'h0);    apb_read(A_TIER);
      expect_rd("rst_tcnt", 32'h0);    apb_read(A_TCNT);
      expect_rd("rst_tcmp", 32'h0);    apb_read(A_TCMP);

      // All-ones writes, masked readback
      apb_write(A_TDR,  32'hFFFF_FFFF);
      apb_write(A_TIER, 32'hFFFF_FFFF);
      apb_write(A_TCMP, 32'hFFFF_FFFF);
      apb_write(A_TSR,  32'hFFFF_FFFF);
      apb_write(A_BAD,  32'hFFFF_FFFF);
      apb_write(A_TCR,  32'hFFFF_FFFF);
      expect_rd("ones_tdr", 32'h0000_FFFF); apb_read(A_TDR);
`ifdef TIMER_CMP_EN
      expect_rd("ones_tier", 32'h7);        apb_read(A_TIER);
      expect_rd("ones_tcmp", 32'h0000_FFFF); apb_read(A_TCMP);
`else
      expect_rd("ones_tier", 32'h3);        apb_read(A_TIER);
      expect_rd("ones_tcmp", 32'h0);        apb_read(A_TCMP);
`endif
      expect_rd("ones_tsr", 32'h0);         apb_read(A_TSR);
      expect_rd("ones_tcr", 32'h0000_00FB); apb_read(A_TCR);
      expect_rd("ones_tcnt", 32'h0000_FFFF); apb_read(A_TCNT);
      expect_rd("unmapped", 32'h0);         apb_read(A_BAD);
      apb_write(A_TCR, 32'h0);
      apb_write(A_TSR, 32'h7);
      apb_write(A_TIER, 32'h0);

      // Up count, no divider, wrap to 0 with ovf
      apb_write(A_TDR, 32'h0000_FFFD);
      expect_rd("up_c0", 32'hFFFD);
      expect_rd("up_c1", 32'hFFFE);
      expect_rd("up_c2", 32'hFFFF);
      expect_rd("up_c3", 32'h0000);
      apb_write(A_TCR, 32'h05);
      read_stream(A_TCNT, 4);
      expect_rd_irq("up_ovf", 32'h1, 1'b0); apb_read(A_TSR);
      apb_write(A_TCR, 32'h0);
      apb_write(A_TSR, 32'h7);

      // Down count, divide by 8, auto-reload
      apb_write(A_TDR, 32'h0000_0002);
      for (int k = 0; k < 25; k++)
         expect_rd("down_div8", (k < 8) ? 32'd2 : (k < 16) ? 32'd1 : (k < 24) ? 32'd0 : 32'd2);
      apb_write(A_TCR, 32'hBF);
      read_stream(A_TCNT, 25);
      expect_rd_irq("down_udf", 32'h2, 1'b0); apb_read(A_TSR);
      apb_write(A_TCR, 32'h0);
      apb_write(A_TSR, 32'h7);

      // Pause and resume
      apb_write(A_TDR, 32'h0000_000C);
      apb_write(A_TCR, 32'h05);
      idle(2);
      apb_write(A_TCR, 32'h00);
      idle(50);
      expect_rd("pause_hold", 32'h10); apb_read(A_TCNT);
      expect_rd("resume_c0", 32'h10);
      expect_rd("resume_c1", 32'h11);
      apb_write(A_TCR, 32'h01);
      read_stream(A_TCNT, 2);
      apb_write(A_TCR, 32'h0);

      // Interrupt and write-1-to-clear
      apb_write(A_TIER, 32'h1);
      apb_write(A_TDR, 32'h0000_FFFF);
      apb_write(A_TCR, 32'h05);
      apb_write(A_TCR, 32'h00);
      expect_rd_irq("irq_set", 32'h1, 1'b1); apb_read(A_TSR);
      apb_write(A_TSR, 32'h1);
      expect_rd_irq("irq_w1c", 32'h0, 1'b0); apb_read(A_TSR);
      apb_write(A_TDR, 32'h0000_FFFE);
      apb_write(A_TCR, 32'h05);
      apb_write(A_TSR, 32'h1);
      expect_rd_irq("set_beats_clr", 32'h1, 1'b1); apb_read(A_TSR);
      apb_write(A_TCR, 32'h0);
      apb_write(A_TSR, 32'h7);
      expect_rd_irq("irq_final_clr", 32'h0, 1'b0); apb_read(A_TSR);
      apb_write(A_TIER, 32'h0);

`ifdef TIMER_CMP_EN
      // Compare match
      apb_write(A_TDR, 32'h0);
      apb_write(A_TCMP, 32'h20);
      apb_write(A_TIER, 32'h4);
      for (int k = 0; k < 34; k++)
         expect_rd_irq("cmp_cnt", 32'(k), k >= 32);
      apb_write(A_TCR, 32'h05);
      read_stream(A_TCNT, 34);
      expect_rd("cmp_flag", 32'h4); apb_read(A_TSR);
      apb_write(A_TCR, 32'h0);
      apb_write(A_TSR, 32'h7);
      apb_write(A_TDR, 32'h20);
      apb_write(A_TCR, 32'h04);
      expect_rd("load_no_cmp_cnt", 32'h20); apb_read(A_TCNT);
      expect_rd_irq("load_no_cmp", 32'h0, 1'b0); apb_read(A_TSR);
      apb_write(A_TIER, 32'h0);
`else
      apb_write(A_TIER, 32'h4);
      expect_rd("tier_bit2_ro", 32'h0); apb_read(A_TIER);
      apb_write(A_TCMP, 32'h20);
      expect_rd("tcmp_reserved", 32'h0); apb_read(A_TCMP);
      apb_write(A_TIER, 32'h0);
`endif

      // Asynchronous reset mid-count
      apb_write(A_TDR, 32'h0000_0100);
      apb_write(A_TCR, 32'h05);
      idle(5);
      presetn = 1'b0;
      idle(2);
      presetn = 1'b1;
      idle(1);
      expect_rd("arst_tcr", 32'h0);  apb_read(A_TCR);
      expect_rd("arst_tdr", 32'h0);  apb_read(A_TDR);
      idle(10);
      expect_rd_irq("arst_tcnt", 32'h0, 1'b0); apb_read(A_TCNT);

      idle(2);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
